// File: rtl/wave_capture_ctrl.sv
// -----------------------------------------------------------------------------
// wave_capture_ctrl
//
// Acquisition-side producer for one display channel. Keeps a circular
// DEPTH-sample history of the ADC stream. It arms after PRE samples and
// captures on a level crossing, or on an auto timeout. Once the window is
// complete it holds the buffer and plays one DEPTH-sample window out as a
// gap-free burst when the display asks for it.
//
// Ports
//   clk            sole clock (ADC and readout side)
//   reset          synchronous, active-high
//   adc_data[7:0]  unsigned ADC sample, qualified by adc_valid
//   adc_valid      adc_data valid this cycle
//   trig_level[7:0] trigger threshold (unsigned, used live)
//   trig_edge      0 = rising, 1 = falling (used live)
//   single_mode    1 = single-shot, 0 = continuous
//   auto_en        enables forced capture (continuous mode only)
//   arm            pulse, re-arms after a single-shot capture
//   rd_req         pulse, requests a readout (honoured only in HOLD)
//   O_wave_data    readout sample, holds its last value between bursts
//   O_wave_data_de readout sample valid
//   O_triggered    1 = last capture was a real trigger, 0 = forced / none
//   O_state        current FSM state code
// -----------------------------------------------------------------------------
module wave_capture_ctrl #(
  parameter int DEPTH   = 750,
  parameter int PRE     = 375,
  parameter int AUTO_TO = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  input  logic [7:0] trig_level,
  input  logic       trig_edge,
  input  logic       single_mode,
  input  logic       auto_en,
  input  logic       arm,
  input  logic       rd_req,
  output logic [7:0] O_wave_data,
  output logic       O_wave_data_de,
  output logic       O_triggered,
  output logic [2:0] O_state
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW     = $clog2(AUTO_TO) + 1;
  localparam int POST_N = DEPTH - PRE - 1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TO - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BACKOFF   = (AW+1)'(DEPTH - PRE);
  localparam logic          NO_POST   = (POST_N == 0);

  typedef enum logic [2:0] {
    S_PRE_FILL = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_HOLD     = 3'd3,
    S_READ     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;          // pre-fill / post / readout counter
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    prev_q, prev_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic          triggered_q, triggered_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_issue_q, rd_issue_d; // rd_data_q holds a burst sample
  logic [7:0]    rd_data_q;
  logic [7:0]    wave_q;
  logic          wave_de_q;

  logic [7:0]    mem [DEPTH];

  logic          wr_en;
  logic          trig_hit;
  logic          to_hit;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_start;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  assign wr_en = adc_valid &&
                 (state_q == S_PRE_FILL || state_q == S_ARMED || state_q == S_POST);

  assign trig_hit = trig_edge ? ((prev_q > trig_level) && (adc_data <= trig_level))
                              : ((prev_q < trig_level) && (adc_data >= trig_level));

  // to_cnt saturates at AUTO_TO-1, so a timeout enabled late fires on the next sample.
  assign to_hit = auto_en && !single_mode && (to_cnt_q == TO_LAST);

  // (trig_ptr - PRE) mod DEPTH without a negative intermediate.
  always_comb begin
    rd_sum   = {1'b0, trig_ptr_q} + BACKOFF;
    rd_start = rd_sum[AW-1:0];
    if (rd_sum >= DEPTH_X) begin
      rd_start = AW'(rd_sum - DEPTH_X);
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    to_cnt_d    = to_cnt_q;
    prev_d      = prev_q;
    trig_ptr_d  = trig_ptr_q;
    triggered_d = triggered_q;
    rd_addr_d   = rd_addr_q;
    rd_issue_d  = 1'b0;

    if (wr_en) begin
      wr_ptr_d = addr_inc(wr_ptr_q);
      prev_d   = adc_data;
    end

    unique case (state_q)
      S_PRE_FILL: begin
        if (adc_valid) begin
          if (cnt_q == PRE_LAST) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_ARMED: begin
        if (adc_valid) begin
          if (trig_hit || to_hit) begin
            trig_ptr_d  = wr_ptr_q;
            triggered_d = trig_hit;   // real trigger wins over a timeout
            cnt_d       = '0;
            state_d     = NO_POST ? S_HOLD : S_POST;
          end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      S_POST: begin
        if (adc_valid) begin
          if (cnt_q == POST_LAST) begin
            state_d = S_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_HOLD: begin
        if (rd_req) begin
          state_d   = S_READ;
          rd_addr_d = rd_start;
          cnt_d     = '0;
        end else if (arm && single_mode) begin
          state_d  = S_PRE_FILL;
          cnt_d    = '0;
          to_cnt_d = '0;
        end
      end

      S_READ: begin
        rd_issue_d = 1'b1;
        rd_addr_d  = addr_inc(rd_addr_q);
        if (cnt_q == LAST_ADDR) begin
          cnt_d = '0;
          if (single_mode) begin
            state_d = S_HOLD;
          end else begin
            state_d  = S_PRE_FILL;
            to_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_PRE_FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PRE_FILL;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      prev_q      <= '0;
      trig_ptr_q  <= '0;
      triggered_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_issue_q  <= 1'b0;
      wave_q      <= '0;
      wave_de_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      prev_q      <= prev_d;
      trig_ptr_q  <= trig_ptr_d;
      triggered_q <= triggered_d;
      rd_addr_q   <= rd_addr_d;
      rd_issue_q  <= rd_issue_d;
      wave_de_q   <= rd_issue_q;
      if (rd_issue_q) begin
        wave_q <= rd_data_q;
      end
    end
  end

  // Sample buffer: kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= adc_data;
    end
    rd_data_q <= mem[rd_addr_q];
  end

  assign O_wave_data    = wave_q;
  assign O_wave_data_de = wave_de_q;
  assign O_triggered    = triggered_q;
  assign O_state        = state_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
module tb_wave_capture_ctrl;

  localparam int DEPTH   = 8;
  localparam int PRE     = 3;
  localparam int AUTO_TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] adc_data = '0;
  logic       adc_valid = 1'b0;
  logic [7:0] trig_level = 8'h80;
  logic       trig_edge = 1'b0;
  logic       single_mode = 1'b0;
  logic       auto_en = 1'b0;
  logic       arm = 1'b0;
  logic       rd_req = 1'b0;
  logic [7:0] O_wave_data;
  logic       O_wave_data_de;
  logic       O_triggered;
  logic [2:0] O_state;

  always #5 clk = ~clk;

  wave_capture_ctrl #(.DEPTH(DEPTH), .PRE(PRE), .AUTO_TO(AUTO_TO)) dut (
    .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_edge(trig_edge), .single_mode(single_mode),
    .auto_en(auto_en), .arm(arm), .rd_req(rd_req),
    .O_wave_data(O_wave_data), .O_wave_data_de(O_wave_data_de),
    .O_triggered(O_triggered), .O_state(O_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phases use the published state codes. The window handed out on a read is
  // simply the last DEPTH samples accepted into the history, oldest first.
  int cyc = 0;
  bit m_live = 0;
  int m_phase = 0, m_n = 0, m_arm_n = 0, m_post_left = 0, m_rd_left = 0;
  int m_prev = 0;
  bit m_trig = 0;
  bit m_bvalid = 0;
  int m_bstart = 0;
  int m_burst [DEPTH];
  int hist [$];
  bit m_exp_de = 0;
  int m_exp_data = 0;
  int d, lvl;
  bit hit, forced;
  logic [7:0] cap [$];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    if (reset) begin
      m_live = 1; m_phase = 0; m_n = 0; m_arm_n = 0; m_prev = 0; m_trig = 0;
      m_bvalid = 0; m_exp_de = 0; m_exp_data = 0;
      hist.delete();
    end else begin
      m_exp_de = m_bvalid && (cyc >= m_bstart + 2) && (cyc <= m_bstart + DEPTH + 1);
      if (m_exp_de) m_exp_data = m_burst[cyc - m_bstart - 2];
      if (m_phase <= 2) begin
        if (adc_valid) begin
          d   = int'(adc_data);
          lvl = int'(trig_level);
          if (m_phase == 0) begin
            m_n++;
            if (m_n == PRE) m_phase = 1;
          end else if (m_phase == 1) begin
            m_arm_n++;
            hit = trig_edge ? (m_prev > lvl && d <= lvl) : (m_prev < lvl && d >= lvl);
            forced = auto_en && !single_mode && (m_arm_n >= AUTO_TO);
            if (hit || forced) begin
              m_trig = hit;
              m_post_left = DEPTH - PRE - 1;
              m_phase = (m_post_left == 0) ? 3 : 2;
            end
          end else begin
            m_post_left--;
            if (m_post_left == 0) m_phase = 3;
          end
          hist.push_back(d);
          if (hist.size() > DEPTH) void'(hist.pop_front());
          m_prev = d;
        end
      end else if (m_phase == 3) begin
        if (rd_req) begin
          for (int i = 0; i < DEPTH; i++) m_burst[i] = (i < hist.size()) ? hist[i] : 0;
          m_bstart = cyc; m_bvalid = 1; m_rd_left = DEPTH; m_phase = 4;
        end else if (arm && single_mode) begin
          m_phase = 0; m_n = 0; m_arm_n = 0;
        end
      end else begin
        m_rd_left--;
        if (m_rd_left == 0) begin
          if (single_mode) m_phase = 3;
          else begin m_phase = 0; m_n = 0; m_arm_n = 0; end
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      chk("cyc_de", O_wave_data_de, m_exp_de);
      chk("cyc_data", O_wave_data, m_exp_data);
      chk("cyc_state", O_state, m_phase);
      chk("cyc_triggered", O_triggered, m_trig);
      if (O_wave_data_de === 1'b1) cap.push_back(O_wave_data);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; adc_valid = 0; rd_req = 0; arm = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic send(input logic [7:0] v);
    adc_valid = 1; adc_data = v;
    tick();
    adc_valid = 0;
    if ($urandom_range(0, 2) == 0) tick();
  endtask

  task automatic feed_ramp(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      send(v);
      v = v + step;
    end
  endtask

  task automatic read_burst(input logic with_arm);
    cap.delete();
    rd_req = 1; arm = with_arm; adc_data = 8'($urandom);
    tick();
    rd_req = 0; arm = 0;
    repeat (DEPTH + 4) begin
      adc_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic chk_burst(input string nm, input logic [0:7][7:0] exp);
    chk({nm, "_len"}, cap.size(), DEPTH);
    for (int k = 0; k < DEPTH; k++)
      if (k < cap.size()) chk($sformatf("%s_k%0d", nm, k), cap[k], exp[k]);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic            edge_f, single, auto_e;
    logic [7:0]      level, start, step;
    int              nsamp, chk_at, chk_state;
    logic [0:7][7:0] exp_burst;
    logic            exp_trig;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h80, 8'h00, 8'h20, 9, 4, 1,
                {8'h20, 8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0, 8'hE0, 8'h00}, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h80, 8'hF0, 8'hF0, 12, 7, 1,
                {8'hB0, 8'hA0, 8'h90, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40}, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h80, 8'h10, 8'h00, 23, 18, 1,
                {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10}, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h80, 8'h10, 8'h20, 9, 5, 2,
                {8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h10}, 1'b1};

    tick(); tick();
    do_reset();
    chk("rst_data", O_wave_data, 0);
    chk("rst_de", O_wave_data_de, 0);
    chk("rst_trig", O_triggered, 0);
    chk("rst_state", O_state, 0);

    foreach (vecs[i]) begin
      logic [7:0] v;
      trig_edge = vecs[i].edge_f; single_mode = vecs[i].single;
      auto_en = vecs[i].auto_e; trig_level = vecs[i].level;
      do_reset();
      v = vecs[i].start;
      for (int s = 0; s < vecs[i].nsamp; s++) begin
        send(v);
        v = v + vecs[i].step;
        if (s + 1 == vecs[i].chk_at)
          chk($sformatf("vec%0d_mid_state", i), O_state, vecs[i].chk_state);
      end
      chk($sformatf("vec%0d_hold", i), O_state, 3);
      read_burst(1'b0);
      chk_burst($sformatf("vec%0d", i), vecs[i].exp_burst);
      chk($sformatf("vec%0d_trig", i), O_triggered, vecs[i].exp_trig);
      $display("[TB] vector %0d done, burst of %0d samples", i, cap.size());
    end

    // Single-shot replay: HOLD keeps the window while the ADC keeps moving.
    adc_valid = 1;
    read_burst(1'b0);
    chk_burst("replay", vecs[3].exp_burst);
    chk("replay_hold", O_state, 3);
    adc_valid = 0;
    arm = 1; tick(); arm = 0;
    chk("rearm_state", O_state, 0);
    feed_ramp(8'h05, 8'h20, 9);
    read_burst(1'b0);
    chk_burst("rearm", {8'h25, 8'h45, 8'h65, 8'h85, 8'hA5, 8'hC5, 8'hE5, 8'h05});
    chk("rearm_trig", O_triggered, 1);
    $display("[TB] single-shot replay and re-arm done");

    // Write-pointer wrap: third capture triggers at address 2, window starts at 7.
    single_mode = 0; trig_edge = 0; auto_en = 0; trig_level = 8'h80;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      feed_ramp(8'h00, 8'h20, 9);
      read_burst(1'b0);
      chk_burst($sformatf("wrap%0d", c), vecs[0].exp_burst);
    end
    feed_ramp(8'h00, 8'h10, 13);
    read_burst(1'b0);
    chk_burst("wrap2", {8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0});
    single_mode = 1;
    feed_ramp(8'h00, 8'h20, 9);
    read_burst(1'b1);
    chk_burst("rd_arm", vecs[0].exp_burst);
    chk("rd_arm_state", O_state, 3);
    $display("[TB] wrap captures and rd_req+arm done");

    // Reset in the middle of a burst.
    cap.delete();
    rd_req = 1; tick(); rd_req = 0;
    repeat (5) tick();
    reset = 1; tick();
    chk("midrst_de", O_wave_data_de, 0);
    chk("midrst_data", O_wave_data, 0);
    chk("midrst_state", O_state, 0);
    chk("midrst_trig", O_triggered, 0);
    chk("midrst_len", cap.size(), 4);
    reset = 0; tick();
    cap.delete();
    rd_req = 1; tick(); rd_req = 0;
    repeat (12) tick();
    chk("prefill_rd_len", cap.size(), 0);
    chk("prefill_rd_state", O_state, 0);
    $display("[TB] mid-burst reset done");

    // Randomised traffic, checked cycle by cycle against the model.
    single_mode = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      adc_valid   = ($urandom_range(0, 3) != 0);
      adc_data    = 8'($urandom);
      rd_req      = ($urandom_range(0, 29) == 0);
      arm         = ($urandom_range(0, 49) == 0);
      reset       = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 499) == 0) single_mode = ~single_mode;
      if ($urandom_range(0, 299) == 0) trig_edge = ~trig_edge;
      if ($urandom_range(0, 199) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 399) == 0) trig_level = 8'($urandom);
      tick();
    end
    adc_valid = 0; rd_req = 0; arm = 0; reset = 0;
    repeat (DEPTH + 4) tick();
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
